stopwatch_mode_controller: RTL and testbench



---
 rtl/stopwatch_mode_controller.sv | 107 ++++++++++
 tb/tb_stopwatch_mode_controller.sv | 132 +++++++++++++
 2 files changed

// File: rtl/stopwatch_mode_controller.sv
// stopwatch_mode_controller: run/stop/clear sequencing plus time-set mode with adjust pulses, timeout and blink.
module stopwatch_mode_controller #(
  parameter int TIMEOUT_TICKS = 1000,
  parameter int BLINK_TICKS   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_100hz,
  input  logic       btn_L,
  input  logic       btn_R,
  input  logic       btn_M,
  input  logic       btn_U,
  input  logic       btn_D,
  output logic       run_stop,
  output logic       clear,
  output logic       inc_hour,
  output logic       dec_hour,
  output logic       inc_min,
  output logic       dec_min,
  output logic       inc_sec,
  output logic       dec_sec,
  output logic [1:0] set_field,
  output logic       blink
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [2:0] {STOP, RUN, CLR, SET_HOUR, SET_MIN, SET_SEC} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          blink_q, blink_d;
  logic [5:0]    adj_q, adj_d;
  logic [1:0]    field_q, field_d;
  logic          run_q, clr_q;
  logic          set_st, set_d, hr, mn, sc, inc, dec, press;

  assign set_st = state_q inside {SET_HOUR, SET_MIN, SET_SEC};
  assign set_d  = state_d inside {SET_HOUR, SET_MIN, SET_SEC};
  assign hr     = state_q == SET_HOUR;
  assign mn     = state_q == SET_MIN;
  assign sc     = state_q == SET_SEC;
  assign inc    = btn_U;
  assign dec    = btn_D & ~btn_U;
  assign press  = btn_M | btn_U | btn_D;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    state_d = btn_M ? SET_HOUR : btn_R ? CLR : btn_L ? RUN : STOP;
      RUN:     state_d = btn_L ? STOP : RUN;
      CLR:     state_d = STOP;
      default: state_d = btn_M ? (hr ? SET_MIN : mn ? SET_SEC : STOP)
                       : btn_L ? STOP
                       : (!press && i_tick_100hz && tmo_q == TMO_LAST) ? STOP
                       : state_q;
    endcase
  end

  // btn_M in a set state always changes field, so it suppresses any adjust pulse
  assign adj_d = (set_st && !btn_M) ? {hr & inc, hr & dec, mn & inc, mn & dec, sc & inc, sc & dec} : 6'b0;

  assign field_d = (state_d == SET_HOUR) ? 2'd1 : (state_d == SET_MIN) ? 2'd2 : (state_d == SET_SEC) ? 2'd3 : 2'd0;

  // Leaving set mode or changing field restarts both counters with blink low
  always_comb begin
    tmo_d   = '0;
    blk_d   = '0;
    blink_d = 1'b0;
    if (set_d && state_d == state_q) begin
      tmo_d   = press ? '0 : i_tick_100hz ? tmo_q + TW'(1) : tmo_q;
      blk_d   = !i_tick_100hz ? blk_q : (blk_q == BLK_LAST) ? '0 : blk_q + BW'(1);
      blink_d = (i_tick_100hz && blk_q == BLK_LAST) ? ~blink_q : blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STOP;
      tmo_q   <= '0;
      blk_q   <= '0;
      blink_q <= 1'b0;
      adj_q   <= '0;
      field_q <= '0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      blk_q   <= blk_d;
      blink_q <= blink_d;
      adj_q   <= adj_d;
      field_q <= field_d;
      run_q   <= state_d == RUN;
      clr_q   <= state_d == CLR;
    end
  end

  assign run_stop  = run_q;
  assign clear     = clr_q;
  assign {inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec} = adj_q;
  assign set_field = field_q;
  assign blink     = blink_q;
endmodule

// File: tb/tb_stopwatch_mode_controller.sv
// tb_stopwatch_mode_controller: directed scoreboard bench for the stopwatch mode controller.
module tb_stopwatch_mode_controller;
  logic clk = 1'b0;
  logic reset, i_tick_100hz, btn_L, btn_R, btn_M, btn_U, btn_D;
  logic run_stop, clear, inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec, blink;
  logic [1:0] set_field;

  localparam logic [4:0] N = 5'b00000, L = 5'b10000, R = 5'b01000, M = 5'b00100, U = 5'b00010, D = 5'b00001;
  localparam logic [5:0] IH = 6'b100000, IM = 6'b001000, DM = 6'b000100;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb[$];
  string       tq[$];

  stopwatch_mode_controller #(.TIMEOUT_TICKS(5), .BLINK_TICKS(2)) dut (
    .clk(clk), .reset(reset), .i_tick_100hz(i_tick_100hz),
    .btn_L(btn_L), .btn_R(btn_R), .btn_M(btn_M), .btn_U(btn_U), .btn_D(btn_D),
    .run_stop(run_stop), .clear(clear),
    .inc_hour(inc_hour), .dec_hour(dec_hour), .inc_min(inc_min), .dec_min(dec_min),
    .inc_sec(inc_sec), .dec_sec(dec_sec), .set_field(set_field), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ex(logic rs, logic cl, logic [5:0] a, logic [1:0] f, logic b);
    return {rs, cl, a, f, b};
  endfunction

  task automatic step(string tag, logic rst, logic [4:0] b, logic t, logic [10:0] exp);
    logic [10:0] got, want;
    string       name;
    reset = rst;
    {btn_L, btn_R, btn_M, btn_U, btn_D} = b;
    i_tick_100hz = t;
    sb.push_back(exp);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    got  = {run_stop, clear, inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec, set_field, blink};
    want = sb.pop_front();
    name = tq.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", name, got, want);
    end
  endtask

  initial begin
    logic [10:0] Z, RS, H, H1, M0, M1, S0, S1;
    Z  = ex(0, 0, 0, 0, 0);
    RS = ex(1, 0, 0, 0, 0);
    H  = ex(0, 0, 0, 1, 0);
    H1 = ex(0, 0, 0, 1, 1);
    M0 = ex(0, 0, 0, 2, 0);
    M1 = ex(0, 0, 0, 2, 1);
    S0 = ex(0, 0, 0, 3, 0);
    S1 = ex(0, 0, 0, 3, 1);
    step("reset0", 1, N, 0, Z);
    step("reset1", 1, N, 0, Z);
    for (int i = 0; i < 7; i++) step("idle_stop", 0, N, 1, Z);
    step("run_on", 0, L, 0, RS);
    step("run_hold", 0, N, 1, RS);
    step("run_ign_R", 0, R, 0, RS);
    step("run_ign_M", 0, M, 0, RS);
    step("run_ign_UD", 0, U | D, 0, RS);
    for (int i = 0; i < 5; i++) step("run_hold2", 0, N, 0, RS);
    step("run_off", 0, L, 0, Z);
    for (int i = 0; i < 8; i++) step("idle_stop2", 0, N, 0, Z);
    step("clear_on", 0, R, 0, ex(0, 1, 0, 0, 0));
    step("clear_ign_L", 0, L, 0, Z);
    step("clear_after", 0, N, 0, Z);
    step("lrm_prio", 0, L | R | M, 0, H);
    step("inc_h1", 0, U, 0, ex(0, 0, IH, 1, 0));
    step("inc_h1_end", 0, N, 0, H);
    step("inc_h2", 0, U, 0, ex(0, 0, IH, 1, 0));
    step("inc_h2_end", 0, N, 0, H);
    step("inc_h3", 0, U, 0, ex(0, 0, IH, 1, 0));
    step("inc_h3_end", 0, N, 0, H);
    step("ud_inc_only", 0, U | D, 0, ex(0, 0, IH, 1, 0));
    step("to_min", 0, M, 0, M0);
    step("dec_min", 0, D, 0, ex(0, 0, DM, 2, 0));
    step("dec_min_end", 0, N, 0, M0);
    step("m_beats_u", 0, M | U, 0, S0);
    step("sec_to_stop", 0, M, 0, Z);
    step("enter_h", 0, M, 0, H);
    step("set_ign_R", 0, R, 0, H);
    step("set_exit_L", 0, L, 0, Z);
    step("tmo_enter", 0, M, 0, H);
    step("tmo_t1", 0, N, 1, H);
    step("tmo_t2", 0, N, 1, H1);
    step("tmo_t3", 0, N, 1, H1);
    step("tmo_t4", 0, N, 1, H);
    step("tmo_t5_exit", 0, N, 1, Z);
    step("rst_enter", 0, M, 0, H);
    step("rst_t1", 0, N, 1, H);
    step("rst_t2", 0, N, 1, H1);
    step("rst_t3", 0, N, 1, H1);
    step("rst_t4", 0, N, 1, H);
    step("rst_u", 0, U, 0, ex(0, 0, IH, 1, 0));
    step("rst_a", 0, N, 1, H);
    step("rst_b", 0, N, 1, H1);
    step("rst_c", 0, N, 1, H1);
    step("rst_d", 0, N, 1, H);
    step("term_tick_u", 0, U, 1, ex(0, 0, IH, 1, 0));
    step("term_t1", 0, N, 1, H1);
    step("term_t2", 0, N, 1, H1);
    step("term_t3", 0, N, 1, H);
    step("term_t4", 0, N, 1, H);
    step("term_t5_exit", 0, N, 1, Z);
    step("blk_enter", 0, M, 0, H);
    step("blk_min", 0, M, 0, M0);
    step("blk_t1", 0, N, 1, M0);
    step("blk_t2", 0, N, 1, M1);
    step("blk_hold", 0, N, 0, M1);
    step("blk_m_clear", 0, M, 0, S0);
    step("blk_s_t1", 0, N, 1, S0);
    step("blk_s_t2", 0, N, 1, S1);
    step("blk_exit", 0, L, 0, Z);
    step("blk_stop_tick", 0, N, 1, Z);
    step("blk_stop_tick2", 0, N, 1, Z);
    step("ra_h", 0, M, 0, H);
    step("ra_m", 0, M, 0, M0);
    step("ra_s", 0, M, 0, S0);
    step("ra_reset_u", 1, U, 0, Z);
    step("ra_after", 0, N, 0, Z);
    step("ra_after2", 0, N, 1, Z);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
